// File: rtl/vram_write_arbiter.sv
// Sole write master of the tile VRAM port: round-robin arbitration of two requesters plus a screen-clear sweep.
// Optional build macro VBLANK_WRITE_ONLY_EN restricts grants and sweep progress to vblank cycles.
module vram_write_arbiter #(
  parameter int unsigned TILE_COUNT = 1200,
  parameter int unsigned ADDR_W     = 11
) (
  input  logic              sys_clock,
  input  logic              reset,
`ifdef VBLANK_WRITE_ONLY_EN
  input  logic              vblank,
`endif
  input  logic              clear_req,
  input  logic [1:0]        clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [1:0]        req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [1:0]        req1_data,
  output logic              req1_ready,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [1:0]        vram_data,
  output logic              addr_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_TILE = ADDR_W'(TILE_COUNT - 1);
  localparam logic [ADDR_W-1:0] TILE_LIM  = ADDR_W'(TILE_COUNT);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_next;
  logic [1:0]        clear_col;
  logic [1:0]        clear_col_next;
  logic              last_grant;
  logic              last_grant_next;

  logic              grant_valid;
  logic              grant_sel;
  logic [ADDR_W-1:0] grant_addr;
  logic [1:0]        grant_data;
  logic              ready0;
  logic              ready1;

  logic              we_next;
  logic [ADDR_W-1:0] addr_next;
  logic [1:0]        data_next;
  logic              done_next;
  logic              err_next;
  logic              busy_next;
  logic              avail;

`ifdef VBLANK_WRITE_ONLY_EN
  assign avail = vblank;
`else
  assign avail = 1'b1;
`endif

  assign req0_ready = ready0;
  assign req1_ready = ready1;

  // State register
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, arbitration and next registered-output values
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    clear_col_next  = clear_col;
    last_grant_next = last_grant;
    grant_valid     = 1'b0;
    grant_sel       = 1'b0;
    grant_addr      = req0_addr;
    grant_data      = req0_data;
    ready0          = 1'b0;
    ready1          = 1'b0;
    we_next         = 1'b0;
    addr_next       = vram_addr;
    data_next       = vram_data;
    done_next       = 1'b0;
    err_next        = 1'b0;

    case (state)
      IDLE: begin
        if (clear_req) begin
          state_next     = CLEAR;
          cnt_next       = '0;
          clear_col_next = clear_color;
        end else if (avail) begin
          // Only a tie consults and updates the round-robin pointer
          if (req0_valid && req1_valid) begin
            grant_valid     = 1'b1;
            grant_sel       = ~last_grant;
            last_grant_next = ~last_grant;
          end else if (req0_valid) begin
            grant_valid = 1'b1;
            grant_sel   = 1'b0;
          end else if (req1_valid) begin
            grant_valid = 1'b1;
            grant_sel   = 1'b1;
          end
        end

        if (grant_valid) begin
          ready0     = ~grant_sel;
          ready1     = grant_sel;
          grant_addr = grant_sel ? req1_addr : req0_addr;
          grant_data = grant_sel ? req1_data : req0_data;
          if (grant_addr >= TILE_LIM) begin
            err_next = 1'b1;
          end else begin
            we_next   = 1'b1;
            addr_next = grant_addr;
            data_next = grant_data;
          end
        end
      end

      CLEAR: begin
        if (avail) begin
          we_next   = 1'b1;
          addr_next = cnt;
          data_next = clear_col;
          if (cnt == LAST_TILE) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + ADDR_W'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next == CLEAR);
  end

  // Datapath and registered outputs
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      cnt        <= '0;
      clear_col  <= '0;
      last_grant <= 1'b1;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_data  <= '0;
      clear_done <= 1'b0;
      clear_busy <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      clear_col  <= clear_col_next;
      last_grant <= last_grant_next;
      vram_we    <= we_next;
      vram_addr  <= addr_next;
      vram_data  <= data_next;
      clear_done <= done_next;
      clear_busy <= busy_next;
      addr_err   <= err_next;
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: table of single-cycle vectors plus clear/reset sequences, with an output scoreboard.
module tb_vram_write_arbiter;

  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned TILE_COUNT = 1200;

  typedef struct packed {
    logic              rst;
    logic              clr;
    logic [1:0]        col;
    logic              v0;
    logic [ADDR_W-1:0] a0;
    logic [1:0]        d0;
    logic              v1;
    logic [ADDR_W-1:0] a1;
    logic [1:0]        d1;
  } in_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        data;
    logic              err;
    logic              done;
    logic              busy;
  } out_t;

  typedef struct {
    in_t  in;
    logic r0;
    logic r1;
    out_t o;
  } vec_t;

  logic              sys_clock;
  logic              reset;
  logic              clear_req;
  logic [1:0]        clear_color;
  logic              clear_busy;
  logic              clear_done;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [1:0]        req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [1:0]        req1_data;
  logic              req1_ready;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [1:0]        vram_data;
  logic              addr_err;
`ifdef VBLANK_WRITE_ONLY_EN
  logic              vblank;
`endif

  int checks;
  int errors;
  out_t  sb[$];
  string sb_tag[$];
  logic [ADDR_W-1:0] h_addr;
  logic [1:0]        h_data;
  vec_t  tbl[17];

  vram_write_arbiter #(.TILE_COUNT(TILE_COUNT), .ADDR_W(ADDR_W)) dut (
    .sys_clock  (sys_clock),
    .reset      (reset),
`ifdef VBLANK_WRITE_ONLY_EN
    .vblank     (vblank),
`endif
    .clear_req  (clear_req),
    .clear_color(clear_color),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .vram_we    (vram_we),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .addr_err   (addr_err)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  function automatic vec_t mkv(input logic v0, input logic [ADDR_W-1:0] a0, input logic [1:0] d0,
                               input logic v1, input logic [ADDR_W-1:0] a1, input logic [1:0] d1,
                               input logic r0, input logic r1,
                               input logic we, input logic [ADDR_W-1:0] ea, input logic [1:0] ed,
                               input logic er);
    vec_t v;
    v.in    = '0;
    v.in.v0 = v0;
    v.in.a0 = a0;
    v.in.d0 = d0;
    v.in.v1 = v1;
    v.in.a1 = a1;
    v.in.d1 = d1;
    v.r0    = r0;
    v.r1    = r1;
    v.o     = {we, ea, ed, er, 1'b0, 1'b0};
    return v;
  endfunction

  function automatic out_t o_wr(input logic [ADDR_W-1:0] a, input logic [1:0] d,
                                input logic done, input logic busy);
    h_addr = a;
    h_data = d;
    return {1'b1, a, d, 1'b0, done, busy};
  endfunction

  function automatic out_t o_hold(input logic err, input logic busy);
    return {1'b0, h_addr, h_data, err, 1'b0, busy};
  endfunction

  function automatic out_t o_zero();
    h_addr = '0;
    h_data = '0;
    return '0;
  endfunction

  task automatic check_out();
    out_t  exp;
    out_t  act;
    string tag;
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      tag = sb_tag.pop_front();
      act = {vram_we, vram_addr, vram_data, addr_err, clear_done, clear_busy};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s out: got we=%0b addr=%0d data=%0d err=%0b done=%0b busy=%0b, want we=%0b addr=%0d data=%0d err=%0b done=%0b busy=%0b",
                 tag, act.we, act.addr, act.data, act.err, act.done, act.busy,
                 exp.we, exp.addr, exp.data, exp.err, exp.done, exp.busy);
      end
    end
  endtask

  // Called at a falling edge: check last cycle's outputs, drive, check readies, queue expected outputs
  task automatic cycle(input in_t i, input logic er0, input logic er1, input out_t eo, input string tag);
    check_out();
    reset       = i.rst;
    clear_req   = i.clr;
    clear_color = i.col;
    req0_valid  = i.v0;
    req0_addr   = i.a0;
    req0_data   = i.d0;
    req1_valid  = i.v1;
    req1_addr   = i.a1;
    req1_data   = i.d1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== {er0, er1}) begin
      errors++;
      $display("FAIL %s ready: got r0=%0b r1=%0b, want r0=%0b r1=%0b",
               tag, req0_ready, req1_ready, er0, er1);
    end
    sb.push_back(eo);
    sb_tag.push_back(tag);
    @(negedge sys_clock);
  endtask

  initial begin
    in_t  in;
    out_t o;
    checks = 0;
    errors = 0;
    h_addr = '0;
    h_data = '0;

    tbl[0]  = mkv(1, 11'd10,   2'd1, 0, 11'd0,    2'd0, 1, 0, 1, 11'd10,   2'd1, 0);
    tbl[1]  = mkv(1, 11'd45,   2'd3, 0, 11'd0,    2'd0, 1, 0, 1, 11'd45,   2'd3, 0);
    tbl[2]  = mkv(0, 11'd0,    2'd0, 0, 11'd0,    2'd0, 0, 0, 0, 11'd45,   2'd3, 0);
    tbl[3]  = mkv(1, 11'd100,  2'd0, 1, 11'd200,  2'd1, 1, 0, 1, 11'd100,  2'd0, 0);
    tbl[4]  = mkv(1, 11'd101,  2'd1, 1, 11'd200,  2'd1, 0, 1, 1, 11'd200,  2'd1, 0);
    tbl[5]  = mkv(1, 11'd101,  2'd1, 1, 11'd201,  2'd2, 1, 0, 1, 11'd101,  2'd1, 0);
    tbl[6]  = mkv(1, 11'd102,  2'd2, 1, 11'd201,  2'd2, 0, 1, 1, 11'd201,  2'd2, 0);
    tbl[7]  = mkv(1, 11'd102,  2'd2, 1, 11'd202,  2'd3, 1, 0, 1, 11'd102,  2'd2, 0);
    tbl[8]  = mkv(1, 11'd103,  2'd3, 1, 11'd202,  2'd3, 0, 1, 1, 11'd202,  2'd3, 0);
    tbl[9]  = mkv(0, 11'd0,    2'd0, 1, 11'd1200, 2'd1, 0, 1, 0, 11'd202,  2'd3, 1);
    tbl[10] = mkv(0, 11'd0,    2'd0, 0, 11'd0,    2'd0, 0, 0, 0, 11'd202,  2'd3, 0);
    tbl[11] = mkv(0, 11'd0,    2'd0, 1, 11'd1199, 2'd2, 0, 1, 1, 11'd1199, 2'd2, 0);
    tbl[12] = mkv(1, 11'd2047, 2'd0, 0, 11'd0,    2'd0, 1, 0, 0, 11'd1199, 2'd2, 1);
    tbl[13] = mkv(0, 11'd0,    2'd0, 1, 11'd5,    2'd0, 0, 1, 1, 11'd5,    2'd0, 0);
    tbl[14] = mkv(1, 11'd6,    2'd1, 1, 11'd7,    2'd2, 1, 0, 1, 11'd6,    2'd1, 0);
    tbl[15] = mkv(1, 11'd8,    2'd3, 1, 11'd7,    2'd2, 0, 1, 1, 11'd7,    2'd2, 0);
    tbl[16] = mkv(0, 11'd0,    2'd0, 0, 11'd0,    2'd0, 0, 0, 0, 11'd7,    2'd2, 0);

    reset       = 1'b1;
    clear_req   = 1'b0;
    clear_color = 2'd0;
    req0_valid  = 1'b0;
    req0_addr   = '0;
    req0_data   = '0;
    req1_valid  = 1'b0;
    req1_addr   = '0;
    req1_data   = '0;
`ifdef VBLANK_WRITE_ONLY_EN
    vblank      = 1'b1;
`endif
    repeat (3) @(posedge sys_clock);
    @(negedge sys_clock);
    checks++;
    if ({vram_we, vram_addr, vram_data, addr_err, clear_done, clear_busy} !== '0) begin
      errors++;
      $display("FAIL reset_state: got we=%0b addr=%0d data=%0d err=%0b done=%0b busy=%0b, want all 0",
               vram_we, vram_addr, vram_data, addr_err, clear_done, clear_busy);
    end

    // Single-cycle vectors; reset releases with the first one
    for (int i = 0; i < 17; i++) begin
      h_addr = tbl[i].o.addr;
      h_data = tbl[i].o.data;
      cycle(tbl[i].in, tbl[i].r0, tbl[i].r1, tbl[i].o, $sformatf("vec%0d", i));
    end

    // Full clear in colour 0 with requester 1 waiting throughout
    in = '0;
    in.clr = 1'b1;
    in.col = 2'd0;
    in.v1  = 1'b1;
    in.a1  = 11'd300;
    in.d1  = 2'd1;
    cycle(in, 1'b0, 1'b0, o_hold(1'b0, 1'b1), "clear0_start");
    for (int k = 0; k < int'(TILE_COUNT); k++) begin
      in.clr = (k < 3);
      in.col = 2'd3;
      o = o_wr(ADDR_W'(k), 2'd0, k == int'(TILE_COUNT) - 1, k != int'(TILE_COUNT) - 1);
      cycle(in, 1'b0, 1'b0, o, $sformatf("clear0_k%0d", k));
    end
    in.clr = 1'b0;
    cycle(in, 1'b0, 1'b1, o_wr(11'd300, 2'd1, 1'b0, 1'b0), "clear0_req1_after");
    in = '0;
    cycle(in, 1'b0, 1'b0, o_hold(1'b0, 1'b0), "clear0_done_single");

    // Clear aborted by reset at write 500
    in.clr = 1'b1;
    in.col = 2'd2;
    cycle(in, 1'b0, 1'b0, o_hold(1'b0, 1'b1), "clear1_start");
    in.clr = 1'b0;
    for (int k = 0; k < 500; k++) begin
      cycle(in, 1'b0, 1'b0, o_wr(ADDR_W'(k), 2'd2, 1'b0, 1'b1), $sformatf("clear1_k%0d", k));
    end
    in.rst = 1'b1;
    cycle(in, 1'b0, 1'b0, o_zero(), "clear1_reset");
    in.rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle(in, 1'b0, 1'b0, o_hold(1'b0, 1'b0), $sformatf("post_reset%0d", k));
    end

    // Round-robin pointer back at its reset value: requester 0 wins the tie
    in.v0 = 1'b1; in.a0 = 11'd9;  in.d0 = 2'd1;
    in.v1 = 1'b1; in.a1 = 11'd10; in.d1 = 2'd2;
    cycle(in, 1'b1, 1'b0, o_wr(11'd9, 2'd1, 1'b0, 1'b0), "tie_after_reset");
    in.v0 = 1'b0;
`ifdef VBLANK_WRITE_ONLY_EN
    vblank = 1'b0;
    cycle(in, 1'b0, 1'b0, o_hold(1'b0, 1'b0), "vblank_low");
    vblank = 1'b1;
`endif
    cycle(in, 1'b0, 1'b1, o_wr(11'd10, 2'd2, 1'b0, 1'b0), "req1_single");
    in = '0;
    cycle(in, 1'b0, 1'b0, o_hold(1'b0, 1'b0), "final_idle");
    check_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
